// File: rtl/cond_code_unit.sv
// Y86-64 execute-stage condition-code register, jXX/cmovXX condition evaluator
// and E->M Cnd/valid register. Define CC_PERF_EN to add branch perf counters.
module cond_code_unit #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         e_valid,
  input  logic [3:0]   e_icode,
  input  logic [3:0]   e_ifun,
  input  logic [W-1:0] alu_S,
  input  logic         alu_OF,
  input  logic         exc_pending,
  input  logic         stall_e,
  output logic [2:0]   cc,
  output logic         e_Cnd,
  output logic         m_valid,
  output logic         m_Cnd
`ifdef CC_PERF_EN
  ,
  output logic [31:0]  perf_taken,
  output logic [31:0]  perf_branches
`endif
);

  typedef enum logic [3:0] {
    ICODE_CMOVXX = 4'h2,
    ICODE_OPQ    = 4'h6,
    ICODE_JXX    = 4'h7
  } icode_e;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_AND = 4'h2,
    OP_XOR = 4'h3
  } alu_fn_e;

  typedef enum logic [3:0] {
    C_ALWAYS = 4'h0,
    C_LE     = 4'h1,
    C_L      = 4'h2,
    C_E      = 4'h3,
    C_NE     = 4'h4,
    C_GE     = 4'h5,
    C_G      = 4'h6
  } cond_e;

  typedef struct packed {
    logic zf;
    logic sf;
    logic ovf;
  } cc_t;

  localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, ovf: 1'b0};

  cc_t  cc_q, cc_d;
  logic m_valid_q, m_valid_d;
  logic m_cnd_q, m_cnd_d;
  logic set_cc;
  logic cond_hit;
  logic is_cond_insn;
  logic sf_xor_of;

  assign set_cc = e_valid & (e_icode == ICODE_OPQ) & ~exc_pending & ~stall_e;

  // Flags are only written by arithmetic/logic ops; undefined OPq functions leave them alone.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cc_d = cc_q;
    if (set_cc) begin
      unique case (e_ifun)
        OP_ADD, OP_SUB: cc_d = '{zf: (alu_S == '0), sf: alu_S[W-1], ovf: alu_OF};
        OP_AND, OP_XOR: cc_d = '{zf: (alu_S == '0), sf: alu_S[W-1], ovf: 1'b0};
        default:        cc_d = cc_q;
      endcase
    end
  end

  // Conditions read the latched flags only, so an OPq is visible to the next instruction.
  always_comb begin
    sf_xor_of = cc_q.sf ^ cc_q.ovf;
    cond_hit  = 1'b0;
    unique case (e_ifun)
      C_ALWAYS: cond_hit = 1'b1;
      C_LE:     cond_hit = sf_xor_of | cc_q.zf;
      C_L:      cond_hit = sf_xor_of;
      C_E:      cond_hit = cc_q.zf;
      C_NE:     cond_hit = ~cc_q.zf;
      C_GE:     cond_hit = ~sf_xor_of;
      C_G:      cond_hit = ~sf_xor_of & ~cc_q.zf;
      default:  cond_hit = 1'b0;
    endcase
  end

  assign is_cond_insn = (e_icode == ICODE_CMOVXX) | (e_icode == ICODE_JXX);
  assign e_Cnd        = e_valid & is_cond_insn & cond_hit;

  always_comb begin
    m_valid_d = m_valid_q;
    m_cnd_d   = m_cnd_q;
    if (!stall_e) begin
      m_valid_d = e_valid;
      m_cnd_d   = e_Cnd;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cc_q      <= CC_RESET;
      m_valid_q <= 1'b0;
      m_cnd_q   <= 1'b0;
    end else begin
      cc_q      <= cc_d;
      m_valid_q <= m_valid_d;
      m_cnd_q   <= m_cnd_d;
    end
  end

  assign cc      = cc_q;
  assign m_valid = m_valid_q;
  assign m_Cnd   = m_cnd_q;

`ifdef CC_PERF_EN
  logic [31:0] perf_taken_q, perf_taken_d;
  logic [31:0] perf_branches_q, perf_branches_d;
  logic        is_branch;

  assign is_branch = ~stall_e & e_valid & (e_icode == ICODE_JXX);

  always_comb begin
    perf_branches_d = perf_branches_q;
    perf_taken_d    = perf_taken_q;
    if (is_branch) begin
      perf_branches_d = perf_branches_q + 32'd1;
      if (e_Cnd) perf_taken_d = perf_taken_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_taken_q    <= '0;
      perf_branches_q <= '0;
    end else begin
      perf_taken_q    <= perf_taken_d;
      perf_branches_q <= perf_branches_d;
    end
  end

  assign perf_taken    = perf_taken_q;
  assign perf_branches = perf_branches_q;
`endif

endmodule

// File: doc/cond_code_unit.md
# cond_code_unit

Execute-stage condition-code register and condition evaluator for the Y86-64 pipeline. It consumes the 64-bit result and overflow flag from the ADDSUB/logic ALU on every OPq, latches ZF/SF/OF, and evaluates jXX/cmovXX conditions against the latched flags. It also registers the outcome, together with the instruction's valid bit, into the M stage. It sits directly downstream of the ALU and is the single source of the `Cnd` signal for branch resolution and conditional moves.

## Interface
- `W`, 64, ALU result width.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `e_valid` input 1: E-stage holds a real instruction (0 = bubble).
- `e_icode` input 4: Y86 icode (2 = cmovXX, 6 = OPq, 7 = jXX).
- `e_ifun` input 4: Y86 ifun (OPq: 0 add, 1 sub, 2 and, 3 xor; cond: 0..6).
- `alu_S` input W: ALU result valE.
- `alu_OF` input 1: ALU signed-overflow flag.
- `exc_pending` input 1: M or W stage holds an exception status; suppresses CC update.
- `stall_e` input 1: hold E→M register and CC.
- `cc` output 3: latched {ZF, SF, OF}.
- `e_Cnd` output 1: combinational condition for the current E instruction.
- `m_valid` output 1: registered e_valid.
- `m_Cnd` output 1: registered e_Cnd.

## Operation
- `set_cc = e_valid & (e_icode==6) & ~exc_pending & ~stall_e`.
- On `set_cc`:
  - ZF ← (alu_S == 0).
  - SF ← alu_S[W-1].
  - OF ← alu_OF for ifun 0/1, and 0 for ifun 2/3.
  - OPq with ifun > 3 leaves the CC unchanged.
- `e_Cnd` uses the CC as currently latched, never the same-cycle ALU result. Conditions by ifun:
  - 0 always → 1.
  - 1 le → (SF^OF)|ZF.
  - 2 l → SF^OF.
  - 3 e → ZF.
  - 4 ne → ~ZF.
  - 5 ge → ~(SF^OF).
  - 6 g → ~(SF^OF)&~ZF.
  - ifun 7..15 → 0.
- `e_Cnd` is forced to 0 when `e_valid`=0 or `e_icode` is not 2 or 7.
- E→M register:
  - `stall_e`=1: hold.
  - Otherwise: m_valid ← e_valid, m_Cnd ← e_Cnd.
- Reset values: cc = 3'b100 (ZF=1, SF=0, OF=0), m_valid = 0, m_Cnd = 0.

## Timing
- CC update latency is 1 cycle: an OPq in cycle n affects `e_Cnd` from cycle n+1.
- Back-to-back OPq then jXX: the jXX in cycle n+1 sees the flags from cycle n.
- `m_Cnd` lags `e_Cnd` by exactly 1 cycle, except while stalled.
- `rst` takes priority over stall, suppression and set_cc.
- `rst` asserted mid-stream: CC and M register take reset values on that edge.
- `exc_pending` and OPq in the same cycle: CC unchanged; the E→M register still advances.
- Stall and OPq in the same cycle: CC unchanged. The update is applied when the stall releases, if the OPq is still in E.

## Configuration
- `CC_PERF_EN` defined: the block adds the following outputs.
  - `perf_taken` (32 b): increments each non-stalled cycle with e_valid & e_icode==7 & e_Cnd.
  - `perf_branches` (32 b): increments each non-stalled cycle with e_valid & e_icode==7.
  - Both counters reset to 0 and wrap modulo 2^32.
- `CC_PERF_EN` not defined: no counters and no extra ports; all other behaviour is identical.

## Test plan
- Reset, then idle: cc=3'b100; jXX ifun=3 (je) → e_Cnd=1; m_valid=0 before the first instruction.
- OPq sub with alu_S=0xFFFF_FFFF_FFFF_FFFF, alu_OF=0; next cycle jXX ifun=2 (jl) → cc=3'b010, e_Cnd=1, m_Cnd=1 one cycle later.
- OPq add with alu_S=0x8000_0000_0000_0000, alu_OF=1; next cycle cmov ifun=5 (ge) → cc=3'b011, e_Cnd=1. Repeat with xor and the same alu_OF=1 → OF=0, ge → e_Cnd=0.
- OPq with alu_S=0 while exc_pending=1 → cc keeps its prior value (3'b011); je → e_Cnd=0.
- stall_e=1 for 2 cycles during OPq → cc and m_* are held; the update lands on the release cycle.
- With `CC_PERF_EN`: 5 jXX, 3 of them taken → perf_branches=5, perf_taken=3. A reset pulse mid-sequence clears both counters to 0.
